// File: rtl/video_pkg.sv
// Shared video timing definitions: one-hot axis phase encoding, default
// 640x480 timing constants, colour-bar lookup and colour expansion helpers.
package video_pkg;

   localparam int CNT_W = 32'd11;

   localparam int DEF_H_SYNC = 32'd96;
   localparam int DEF_H_BP   = 32'd48;
   localparam int DEF_H_ACT  = 32'd640;
   localparam int DEF_H_FP   = 32'd16;
   localparam int DEF_V_SYNC = 32'd2;
   localparam int DEF_V_BP   = 32'd33;
   localparam int DEF_V_ACT  = 32'd480;
   localparam int DEF_V_FP   = 32'd10;

   typedef enum logic [3:0] {
      PH_SYNC       = 4'b0001,
      PH_BACKPORCH  = 4'b0010,
      PH_DISPLAY    = 4'b0100,
      PH_FRONTPORCH = 4'b1000
   } phase_t;

   // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [23:0] barColour(input logic [2:0] idx);
      logic [23:0] rgb;
      case (idx)
         3'd0:    rgb = 24'hFFFFFF;
         3'd1:    rgb = 24'hFFFF00;
         3'd2:    rgb = 24'h00FFFF;
         3'd3:    rgb = 24'h00FF00;
         3'd4:    rgb = 24'hFF00FF;
         3'd5:    rgb = 24'hFF0000;
         3'd6:    rgb = 24'h0000FF;
         3'd7:    rgb = 24'h000000;
         default: rgb = 24'h000000;
      endcase
      return rgb;
   endfunction

   function automatic logic [7:0] expand4(input logic [3:0] c);
      return {c, c};
   endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One timing axis: free-running position counter with SYNC/BACKPORCH/
// DISPLAY/FRONTPORCH phase decode and a wrap strobe for cascading.
module video_axis_counter
   import video_pkg::*;
#(
   parameter int SYNC = DEF_H_SYNC,
   parameter int BP   = DEF_H_BP,
   parameter int ACT  = DEF_H_ACT,
   parameter int FP   = DEF_H_FP
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output phase_t           phase,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] BP_START  = CNT_W'(SYNC);
   localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
   localparam logic [CNT_W-1:0] FP_START  = CNT_W'(SYNC + BP + ACT);
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(SYNC + BP + ACT + FP - 32'd1);

   logic [CNT_W-1:0] count_r;
   logic             atLast_s;

   assign atLast_s = (count_r == LAST);

   // position counter, wraps from LAST straight to 0
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable) begin
         if (atLast_s) begin
            count_r <= {CNT_W{1'b0}};
         end else begin
            count_r <= count_r + CNT_W'(1);
         end
      end
   end

   // phase decode from the count
   always_comb begin
      phase = PH_SYNC;
      if (count_r < BP_START) begin
         phase = PH_SYNC;
      end else if (count_r < ACT_START) begin
         phase = PH_BACKPORCH;
      end else if (count_r < FP_START) begin
         phase = PH_DISPLAY;
      end else begin
         phase = PH_FRONTPORCH;
      end
   end

   assign count = count_r;
   assign wrap  = enable & atLast_s;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator with zoomed frame-buffer addressing and a 2-clock
// output pipeline. Optional colour bars: VIDEO_TIMING_GEN_TEST_PATTERN_EN.
module video_timing_gen
   import video_pkg::*;
#(
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   H_ACT     = DEF_H_ACT,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter int   V_ACT     = DEF_V_ACT,
   parameter int   V_FP      = DEF_V_FP,
   parameter logic HS_POL    = 1'b0,
   parameter logic VS_POL    = 1'b0,
   parameter int   ZOOM_LOG2 = 32'd1,
   parameter int   BUF_AW    = 32'd17
) (
   input  logic              piul1Clock,
   input  logic              piul1Reset,
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
   input  logic              piul1PatternSel,
`endif
   input  logic [11:0]       piul12RgbIn,
   output logic [BUF_AW-1:0] poulBufAddr,
   output logic              poul1HSync,
   output logic              poul1VSync,
   output logic              poul1Blank_n,
   output logic [7:0]        poul8Red,
   output logic [7:0]        poul8Green,
   output logic [7:0]        poul8Blue,
   output logic [10:0]       poul11PosX,
   output logic [10:0]       poul11PosY,
   output logic              poul1FrameStart,
   output logic              poul1LineStart
);

   localparam int               H_ACT_Z = H_ACT >> ZOOM_LOG2;
   localparam logic [CNT_W-1:0] H_ORG   = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] V_ORG   = CNT_W'(V_SYNC + V_BP);

   logic [CNT_W-1:0] hCount_s, vCount_s, xPix_s, yPix_s;
   phase_t           hPhase_s, vPhase_s;
   logic             hWrap_s, active_s;
   logic [23:0]      rgbNext_s;

   logic             s1Active_r, s1HSync_r, s1VSync_r, s1Frame_r, s1Line_r;
   logic [CNT_W-1:0] s1X_r, s1Y_r;

   video_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)) hAxis (
      .clock(piul1Clock), .reset(piul1Reset), .enable(1'b1),
      .count(hCount_s), .phase(hPhase_s), .wrap(hWrap_s)
   );

   // the vertical wrap coincides with the horizontal one, so it needs no consumer
   video_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)) vAxis (
      .clock(piul1Clock), .reset(piul1Reset), .enable(hWrap_s),
      .count(vCount_s), .phase(vPhase_s), .wrap()
   );

   assign active_s = (hPhase_s == PH_DISPLAY) && (vPhase_s == PH_DISPLAY);

   // stage 0: active coordinates and frame-buffer address
   always_comb begin
      xPix_s      = {CNT_W{1'b0}};
      yPix_s      = {CNT_W{1'b0}};
      poulBufAddr = {BUF_AW{1'b0}};
      if (active_s) begin
         xPix_s      = hCount_s - H_ORG;
         yPix_s      = vCount_s - V_ORG;
         poulBufAddr = BUF_AW'(32'(yPix_s >> ZOOM_LOG2) * 32'(H_ACT_Z)
                               + 32'(xPix_s >> ZOOM_LOG2));
      end else begin
         poulBufAddr = {BUF_AW{1'b0}};
      end
   end

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
   localparam int BAR_W = ((H_ACT / 32'd8) > 32'd0) ? (H_ACT / 32'd8) : 32'd1;
   logic [CNT_W-1:0] barDiv_s;
   logic [2:0]       s1Bar_r;

   assign barDiv_s = xPix_s / CNT_W'(BAR_W);

   // bar index travels with the pixel it belongs to
   always_ff @(posedge piul1Clock or posedge piul1Reset) begin
      if (piul1Reset) begin
         s1Bar_r <= 3'd0;
      end else begin
         s1Bar_r <= (barDiv_s > CNT_W'(7)) ? 3'd7 : barDiv_s[2:0];
      end
   end
`endif

   // stage 1: timing side-band, aligned with the returning read data
   always_ff @(posedge piul1Clock or posedge piul1Reset) begin
      if (piul1Reset) begin
         s1Active_r <= 1'b0;
         s1HSync_r  <= 1'b0;
         s1VSync_r  <= 1'b0;
         s1Frame_r  <= 1'b0;
         s1Line_r   <= 1'b0;
         s1X_r      <= {CNT_W{1'b0}};
         s1Y_r      <= {CNT_W{1'b0}};
      end else begin
         s1Active_r <= active_s;
         s1HSync_r  <= (hPhase_s == PH_SYNC);
         s1VSync_r  <= (vPhase_s == PH_SYNC);
         s1Frame_r  <= active_s && (xPix_s == {CNT_W{1'b0}}) && (yPix_s == {CNT_W{1'b0}});
         s1Line_r   <= active_s && (xPix_s == {CNT_W{1'b0}});
         s1X_r      <= xPix_s;
         s1Y_r      <= yPix_s;
      end
   end

   // colour source: blanked, bar pattern or replicated RGB444
   always_comb begin
      rgbNext_s = 24'h000000;
      if (s1Active_r) begin
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
         if (piul1PatternSel) begin
            rgbNext_s = barColour(s1Bar_r);
         end else begin
            rgbNext_s = {expand4(piul12RgbIn[11:8]), expand4(piul12RgbIn[7:4]),
                         expand4(piul12RgbIn[3:0])};
         end
`else
         rgbNext_s = {expand4(piul12RgbIn[11:8]), expand4(piul12RgbIn[7:4]),
                      expand4(piul12RgbIn[3:0])};
`endif
      end else begin
         rgbNext_s = 24'h000000;
      end
   end

   // output register stage
   always_ff @(posedge piul1Clock or posedge piul1Reset) begin
      if (piul1Reset) begin
         poul1HSync      <= ~HS_POL;
         poul1VSync      <= ~VS_POL;
         poul1Blank_n    <= 1'b0;
         poul8Red        <= 8'h00;
         poul8Green      <= 8'h00;
         poul8Blue       <= 8'h00;
         poul11PosX      <= 11'd0;
         poul11PosY      <= 11'd0;
         poul1FrameStart <= 1'b0;
         poul1LineStart  <= 1'b0;
      end else begin
         poul1HSync      <= s1HSync_r ? HS_POL : ~HS_POL;
         poul1VSync      <= s1VSync_r ? VS_POL : ~VS_POL;
         poul1Blank_n    <= s1Active_r;
         poul8Red        <= rgbNext_s[23:16];
         poul8Green      <= rgbNext_s[15:8];
         poul8Blue       <= rgbNext_s[7:0];
         poul11PosX      <= s1X_r;
         poul11PosY      <= s1Y_r;
         poul1FrameStart <= s1Frame_r;
         poul1LineStart  <= s1Line_r;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 44x15 timing (HT=44, VT=15,
// active 32x8 starting at h=8, v=5); frame = 660 clocks, latency 2 clocks.
`timescale 1ns/1ps
module tb_video_timing_gen;

   localparam int HS = 5, HB = 3, HA = 32, HF = 4;
   localparam int VS = 2, VB = 3, VA = 8,  VF = 2;

   logic        clk, rst;
   logic [11:0] rgbIn;
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
   logic        patSel;
`endif
   logic [16:0] bufAddr, bufAddr2;
   logic        hsync, vsync, blankN, frameStart, lineStart;
   logic        hsync2, vsync2, blankN2, frameStart2, lineStart2;
   logic [7:0]  red, green, blue, red2, green2, blue2;
   logic [10:0] posX, posY, posX2, posY2;
   int          checks, errors, cyc;

   video_timing_gen #(
      .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
      .HS_POL(1'b0), .VS_POL(1'b0), .ZOOM_LOG2(1), .BUF_AW(17)
   ) dut (
      .piul1Clock(clk), .piul1Reset(rst),
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
      .piul1PatternSel(patSel),
`endif
      .piul12RgbIn(rgbIn), .poulBufAddr(bufAddr),
      .poul1HSync(hsync), .poul1VSync(vsync), .poul1Blank_n(blankN),
      .poul8Red(red), .poul8Green(green), .poul8Blue(blue),
      .poul11PosX(posX), .poul11PosY(posY),
      .poul1FrameStart(frameStart), .poul1LineStart(lineStart)
   );

   video_timing_gen #(
      .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
      .HS_POL(1'b1), .VS_POL(1'b1), .ZOOM_LOG2(1), .BUF_AW(17)
   ) dut2 (
      .piul1Clock(clk), .piul1Reset(rst),
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
      .piul1PatternSel(patSel),
`endif
      .piul12RgbIn(rgbIn), .poulBufAddr(bufAddr2),
      .poul1HSync(hsync2), .poul1VSync(vsync2), .poul1Blank_n(blankN2),
      .poul8Red(red2), .poul8Green(green2), .poul8Blue(blue2),
      .poul11PosX(posX2), .poul11PosY(posY2),
      .poul1FrameStart(frameStart2), .poul1LineStart(lineStart2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] memData(input logic [16:0] a);
      if (a == 17'd17) return 12'hA5C;
      return {a[3:0], ~a[3:0], a[7:4]};
   endfunction

   // synchronous frame-buffer model: data one clock after the address
   always @(posedge clk) rgbIn <= memData(bufAddr);

   // clocks since reset release; cyc==n at a negedge means counters saw value n
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic applyReset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitCyc(input int n);
      int guard;
      guard = 0;
      while (cyc != n && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != n) begin
         checks++; errors++;
         $display("FAIL waitCyc got %0d want %0d", cyc, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL rstHsync got %0b want 1", hsync); end
      checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL rstVsync got %0b want 1", vsync); end
      checks++; if (blankN !== 1'b0) begin errors++; $display("FAIL rstBlank got %0b want 0", blankN); end
      checks++; if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL rstRgb got %h want 000000", {red, green, blue}); end
      checks++; if (bufAddr !== 17'd0) begin errors++; $display("FAIL rstAddr got %0d want 0", bufAddr); end
      checks++; if ({posX, posY} !== 22'd0) begin errors++; $display("FAIL rstPos got %0d,%0d want 0,0", posX, posY); end
      checks++; if ({frameStart, lineStart} !== 2'b00) begin errors++; $display("FAIL rstPulses got %b want 00", {frameStart, lineStart}); end
      checks++; if ({hsync2, vsync2} !== 2'b00) begin errors++; $display("FAIL rstSyncPol1 got %b want 00", {hsync2, vsync2}); end
      rst = 1'b0;
      waitCyc(1);
      checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL latHsync1 got %0b want 1", hsync); end
      waitCyc(2);
      checks++; if ({hsync, vsync} !== 2'b00) begin errors++; $display("FAIL latSync2 got %b want 00", {hsync, vsync}); end
   endtask

   task automatic test_hsync();
      int lowCnt;
      applyReset();
      lowCnt = 0;
      for (int c = 2; c < 46; c++) begin
         waitCyc(c);
         if (hsync == 1'b0) lowCnt++;
      end
      checks++; if (lowCnt != 5) begin errors++; $display("FAIL hsyncWidth got %0d want 5", lowCnt); end
      waitCyc(46);
      checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL hsyncLine2 got %0b want 0", hsync); end
      waitCyc(50);
      checks++; if ({hsync, hsync2} !== 2'b01) begin errors++; $display("FAIL hsyncEnd got %b want 01", {hsync, hsync2}); end
      waitCyc(51);
      checks++; if ({hsync, hsync2} !== 2'b10) begin errors++; $display("FAIL hsyncOff got %b want 10", {hsync, hsync2}); end
   endtask

   task automatic test_vsync();
      int lowCnt;
      applyReset();
      lowCnt = 0;
      for (int c = 2; c < 662; c++) begin
         waitCyc(c);
         if (vsync == 1'b0) lowCnt++;
      end
      checks++; if (lowCnt != 88) begin errors++; $display("FAIL vsyncWidth got %0d want 88", lowCnt); end
   endtask

   task automatic test_blank();
      int blkCnt, lsCnt, fsCnt;
      applyReset();
      waitCyc(229);
      checks++; if (blankN !== 1'b0) begin errors++; $display("FAIL blankEarly got %0b want 0", blankN); end
      waitCyc(230);
      checks++; if ({blankN, frameStart, lineStart} !== 3'b111) begin errors++; $display("FAIL firstPixel got %b want 111", {blankN, frameStart, lineStart}); end
      checks++; if ({posX, posY} !== 22'd0) begin errors++; $display("FAIL firstPos got %0d,%0d want 0,0", posX, posY); end
      waitCyc(261);
      checks++; if ({blankN, posX} !== {1'b1, 11'd31}) begin errors++; $display("FAIL lastPixel got %0b,%0d want 1,31", blankN, posX); end
      waitCyc(262);
      checks++; if ({blankN, posX} !== {1'b0, 11'd0}) begin errors++; $display("FAIL afterLine got %0b,%0d want 0,0", blankN, posX); end
      waitCyc(274);
      checks++; if ({lineStart, frameStart, posY} !== {2'b10, 11'd1}) begin errors++; $display("FAIL line1Start got %b,%0d want 10,1", {lineStart, frameStart}, posY); end
      blkCnt = 0; lsCnt = 0; fsCnt = 0;
      for (int c = 275; c < 935; c++) begin
         waitCyc(c);
         if (blankN == 1'b1) blkCnt++;
         if (lineStart == 1'b1) lsCnt++;
         if (frameStart == 1'b1) fsCnt++;
      end
      checks++; if (blkCnt != 256) begin errors++; $display("FAIL activeCount got %0d want 256", blkCnt); end
      checks++; if (lsCnt != 8) begin errors++; $display("FAIL lineStarts got %0d want 8", lsCnt); end
      checks++; if (fsCnt != 1) begin errors++; $display("FAIL frameStarts got %0d want 1", fsCnt); end
   endtask

   task automatic test_address();
      applyReset();
      waitCyc(260);
      checks++; if (bufAddr !== 17'd0) begin errors++; $display("FAIL addrBlank got %0d want 0", bufAddr); end
      waitCyc(273);
      checks++; if (bufAddr !== 17'd0) begin errors++; $display("FAIL addr11 got %0d want 0", bufAddr); end
      waitCyc(300);
      checks++; if (bufAddr !== 17'd14) begin errors++; $display("FAIL addr28_1 got %0d want 14", bufAddr); end
      waitCyc(318);
      checks++; if (bufAddr !== 17'd17) begin errors++; $display("FAIL addr22 got %0d want 17", bufAddr); end
      waitCyc(567);
      checks++; if (bufAddr !== 17'd63) begin errors++; $display("FAIL addrLast got %0d want 63", bufAddr); end
   endtask

   task automatic test_colour();
      applyReset();
      waitCyc(262);
      checks++; if ({red, green, blue} !== 24'h000000) begin errors++; $display("FAIL rgbBlank got %h want 000000", {red, green, blue}); end
      waitCyc(275);
      checks++; if ({red, green, blue} !== 24'h00FF00) begin errors++; $display("FAIL rgb11 got %h want 00ff00", {red, green, blue}); end
      waitCyc(320);
      checks++; if ({red, green, blue} !== 24'hAA55CC) begin errors++; $display("FAIL rgbA5C got %h want aa55cc", {red, green, blue}); end
      checks++; if ({blankN, posX, posY} !== {1'b1, 11'd2, 11'd2}) begin errors++; $display("FAIL rgbA5Cpos got %0b,%0d,%0d want 1,2,2", blankN, posX, posY); end
      waitCyc(569);
      checks++; if ({red, green, blue} !== 24'hFF0033) begin errors++; $display("FAIL rgbLast got %h want ff0033", {red, green, blue}); end
      checks++; if ({posX, posY} !== {11'd31, 11'd7}) begin errors++; $display("FAIL posLast got %0d,%0d want 31,7", posX, posY); end
   endtask

   task automatic test_frame_wrap();
      applyReset();
      waitCyc(661);
      checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL vsyncPreWrap got %0b want 1", vsync); end
      waitCyc(662);
      checks++; if ({vsync, hsync} !== 2'b00) begin errors++; $display("FAIL syncWrap got %b want 00", {vsync, hsync}); end
      waitCyc(889);
      checks++; if (blankN !== 1'b0) begin errors++; $display("FAIL blankPreFrame2 got %0b want 0", blankN); end
      waitCyc(890);
      checks++; if ({frameStart, blankN, posY} !== {2'b11, 11'd0}) begin errors++; $display("FAIL frame2Start got %b,%0d want 11,0", {frameStart, blankN}, posY); end
   endtask

   task automatic test_mid_reset();
      int fsCnt;
      applyReset();
      waitCyc(300);
      checks++; if (blankN !== 1'b1) begin errors++; $display("FAIL preRstBlank got %0b want 1", blankN); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({blankN, hsync} !== 2'b01) begin errors++; $display("FAIL asyncRstSync got %b want 01", {blankN, hsync}); end
      checks++; if ({red, posX, bufAddr} !== 36'd0) begin errors++; $display("FAIL asyncRstData got %h,%0d,%0d want 0,0,0", red, posX, bufAddr); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      fsCnt = 0;
      for (int c = 1; c < 230; c++) begin
         waitCyc(c);
         if (frameStart == 1'b1) fsCnt++;
      end
      checks++; if (fsCnt != 0) begin errors++; $display("FAIL earlyFrameStart got %0d want 0", fsCnt); end
      waitCyc(230);
      checks++; if (frameStart !== 1'b1) begin errors++; $display("FAIL freshFrameStart got %0b want 1", frameStart); end
   endtask

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
   task automatic test_pattern();
      patSel = 1'b1;
      applyReset();
      waitCyc(230);
      checks++; if ({red, green, blue} !== 24'hFFFFFF) begin errors++; $display("FAIL barWhite got %h want ffffff", {red, green, blue}); end
      waitCyc(234);
      checks++; if ({red, green, blue} !== 24'hFFFF00) begin errors++; $display("FAIL barYellow got %h want ffff00", {red, green, blue}); end
      waitCyc(242);
      checks++; if ({red, green, blue} !== 24'h00FF00) begin errors++; $display("FAIL barGreen got %h want 00ff00", {red, green, blue}); end
      waitCyc(258);
      checks++; if ({blankN, red, green, blue} !== 25'h1000000) begin errors++; $display("FAIL barBlack got %0b,%h want 1,000000", blankN, {red, green, blue}); end
      patSel = 1'b0;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
      patSel = 1'b0;
`endif
      test_reset();
      test_hsync();
      test_vsync();
      test_blank();
      test_address();
      test_colour();
      test_frame_wrap();
      test_mid_reset();
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
